// File: rtl/cmd_point_stack_if.sv
// cmd_point_stack_if: command pointer request/status bundle between sequencer and pointer block
interface cmd_point_stack_if #(
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH_W   = 4
);
  logic                 en;
  logic [2:0]           opcode;
  logic [BUS_WIDTH-1:0] addr_to;
  logic [BUS_WIDTH-1:0] addr_point;
  logic                 ready;
  logic [DEPTH_W-1:0]   depth;
  logic                 fault;
  logic [1:0]           fault_code;
  modport master (
    output en, opcode, addr_to,
    input  addr_point, ready, depth, fault, fault_code
  );
  modport slave (
    input  en, opcode, addr_to,
    output addr_point, ready, depth, fault, fault_code
  );
endinterface

// File: rtl/cmd_point_stack.sv
// cmd_point_stack: command pointer with jump/relative jump, return-address stack, stall and fault state
module cmd_point_stack #(
  parameter int                   BUS_WIDTH      = 32,
  parameter logic [BUS_WIDTH-1:0] CMD_POINT_BASE = '0,
  parameter int                   STACK_DEPTH    = 8,
  parameter int                   DEPTH_W        = $clog2(STACK_DEPTH + 1)
) (
  input logic          clk,
  input logic          nreset,
  cmd_point_stack_if.slave cp
);
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;
  typedef enum logic [2:0] {NUL, JMP, SJF, CALL, SJB, RET, HOLD, RST} op_e;
  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] ptr_q, ptr_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d, top;
  logic [1:0]           code_q, code_d;
  logic                 ready_q, fault_q, push, full, empty;
  logic [BUS_WIDTH-1:0] stk_q [STACK_DEPTH];
  assign full  = depth_q == DEPTH_W'(STACK_DEPTH);
  assign empty = depth_q == '0;
  assign top   = depth_q - DEPTH_W'(1);
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    code_d  = code_q;
    push    = 1'b0;
    if (state_q == BOOT) state_d = RUN;
    else if (cp.en && state_q == RUN) begin
      case (op_e'(cp.opcode))
        NUL: ptr_d = ptr_q + BUS_WIDTH'(1);
        JMP: ptr_d = cp.addr_to;
        SJF: ptr_d = ptr_q + cp.addr_to;
        SJB: ptr_d = ptr_q - cp.addr_to;
        CALL: begin
          state_d = full ? FAULT : RUN;
          code_d  = full ? 2'b01 : code_q;
          push    = !full;
          ptr_d   = full ? ptr_q : cp.addr_to;
          depth_d = full ? depth_q : depth_q + DEPTH_W'(1);
        end
        RET: begin
          state_d = empty ? FAULT : RUN;
          code_d  = empty ? 2'b10 : code_q;
          ptr_d   = empty ? ptr_q : stk_q[top[IDX_W-1:0]];
          depth_d = empty ? depth_q : top;
        end
        RST: begin
          ptr_d   = CMD_POINT_BASE;
          depth_d = '0;
        end
        default: ;
      endcase
    end else if (cp.en && state_q == FAULT && op_e'(cp.opcode) == RST) begin
      state_d = RUN;
      ptr_d   = CMD_POINT_BASE;
      depth_d = '0;
      code_d  = 2'b00;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= BOOT;
      ptr_q   <= CMD_POINT_BASE;
      depth_q <= '0;
      code_q  <= 2'b00;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      code_q  <= code_d;
      ready_q <= state_d == RUN;
      fault_q <= state_d == FAULT;
    end
  end
  // Stack storage has no reset so it can map onto LUT-RAM; depth alone defines validity.
  always_ff @(posedge clk) begin
    if (push) stk_q[depth_q[IDX_W-1:0]] <= ptr_q + BUS_WIDTH'(1);
  end
  assign cp.addr_point = ptr_q;
  assign cp.ready      = ready_q;
  assign cp.depth      = depth_q;
  assign cp.fault      = fault_q;
  assign cp.fault_code = code_q;
endmodule

// File: tb/tb_cmd_point_stack.sv
// tb_cmd_point_stack: two pointer instances (stack depth 2 and 8) driven in lock-step against a queue model
module tb_cmd_point_stack;
  localparam logic [31:0] BASE = 32'h100;
  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        en = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cmd_point_stack_if #(.BUS_WIDTH(32), .DEPTH_W(2)) b0 ();
  cmd_point_stack_if #(.BUS_WIDTH(32), .DEPTH_W(4)) b1 ();
  assign b0.en = en;
  assign b0.opcode = op;
  assign b0.addr_to = a;
  assign b1.en = en;
  assign b1.opcode = op;
  assign b1.addr_to = a;
  cmd_point_stack #(.BUS_WIDTH(32), .CMD_POINT_BASE(BASE), .STACK_DEPTH(2)) u0 (.clk(clk), .nreset(nreset), .cp(b0));
  cmd_point_stack #(.BUS_WIDTH(32), .CMD_POINT_BASE(BASE), .STACK_DEPTH(8)) u1 (.clk(clk), .nreset(nreset), .cp(b1));
  // model: mode 0 boot, 1 run, 2 fault; return addresses kept in a per-instance queue
  int          lim [2] = '{2, 8};
  int          mmode [2];
  logic [31:0] mp [2];
  logic [1:0]  mcode [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  function automatic int qsize(int i);
    return i == 0 ? q0.size() : q1.size();
  endfunction
  function automatic void qpush(int i, logic [31:0] v);
    if (i == 0) q0.push_back(v); else q1.push_back(v);
  endfunction
  function automatic logic [31:0] qpop(int i);
    return i == 0 ? q0.pop_back() : q1.pop_back();
  endfunction
  function automatic void qclear(int i);
    if (i == 0) q0.delete(); else q1.delete();
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mmode[i] = 0;
      mp[i] = BASE;
      mcode[i] = 2'b00;
      qclear(i);
    end
  endfunction
  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      if (mmode[i] == 0) mmode[i] = 1;
      else if (mmode[i] == 2) begin
        if (en && op == 3'd7) begin
          mmode[i] = 1; mp[i] = BASE; mcode[i] = 2'b00; qclear(i);
        end
      end else if (en) begin
        case (op)
          3'd0: mp[i] = mp[i] + 1;
          3'd1: mp[i] = a;
          3'd2: mp[i] = mp[i] + a;
          3'd4: mp[i] = mp[i] - a;
          3'd3: if (qsize(i) < lim[i]) begin qpush(i, mp[i] + 1); mp[i] = a; end
                else begin mmode[i] = 2; mcode[i] = 2'b01; end
          3'd5: if (qsize(i) > 0) mp[i] = qpop(i);
                else begin mmode[i] = 2; mcode[i] = 2'b10; end
          3'd7: begin mp[i] = BASE; qclear(i); end
          default: ;
        endcase
      end
    end
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("addr0", b0.addr_point, mp[0]);
    chk("depth0", 32'(b0.depth), 32'(qsize(0)));
    chk("ready0", 32'(b0.ready), 32'(mmode[0] == 1));
    chk("fault0", 32'(b0.fault), 32'(mmode[0] == 2));
    chk("code0", 32'(b0.fault_code), 32'(mcode[0]));
    chk("addr1", b1.addr_point, mp[1]);
    chk("depth1", 32'(b1.depth), 32'(qsize(1)));
    chk("ready1", 32'(b1.ready), 32'(mmode[1] == 1));
    chk("fault1", 32'(b1.fault), 32'(mmode[1] == 2));
    chk("code1", 32'(b1.fault_code), 32'(mcode[1]));
  endtask
  task automatic cyc(input logic e, input logic [2:0] o, input logic [31:0] v);
    en = e; op = o; a = v;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic do_reset();
    #2;
    nreset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    check_all();
  endtask
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_ready", 32'(b0.ready), 32'd0);
    chk("rst_addr", b0.addr_point, 32'h100);
    for (int k = 0; k < 4; k++) cyc(1'b1, 3'd0, 32'h0);
    chk("nul_seq", b0.addr_point, 32'h103);
    cyc(1'b1, 3'd1, 32'h10);
    cyc(1'b1, 3'd1, 32'h40);
    chk("jmp", b0.addr_point, 32'h40);
    cyc(1'b1, 3'd2, 32'h8);
    chk("sjf", b0.addr_point, 32'h48);
    cyc(1'b1, 3'd4, 32'h50);
    chk("sjb_wrap", b0.addr_point, 32'hFFFFFFF8);
    for (int k = 0; k < 3; k++) cyc(1'b0, 3'd1, 32'h1234);
    chk("stall", b0.addr_point, 32'hFFFFFFF8);
    chk("stall_ready", 32'(b0.ready), 32'd1);
    cyc(1'b1, 3'd1, 32'h20);
    cyc(1'b1, 3'd3, 32'h80);
    cyc(1'b1, 3'd3, 32'hC0);
    chk("nest_depth", 32'(b1.depth), 32'd2);
    cyc(1'b1, 3'd5, 32'h0);
    chk("ret1", b1.addr_point, 32'h81);
    cyc(1'b1, 3'd5, 32'h0);
    chk("ret2", b1.addr_point, 32'h21);
    chk("ret2_depth", 32'(b1.depth), 32'd0);
    cyc(1'b1, 3'd6, 32'h0);
    chk("hold", b0.addr_point, 32'h21);
    cyc(1'b1, 3'd3, 32'h200);
    cyc(1'b1, 3'd3, 32'h300);
    cyc(1'b1, 3'd3, 32'h400);
    chk("ovf_fault", 32'(b0.fault), 32'd1);
    chk("ovf_code", 32'(b0.fault_code), 32'd1);
    chk("ovf_addr", b0.addr_point, 32'h300);
    chk("ovf_depth", 32'(b0.depth), 32'd2);
    cyc(1'b1, 3'd0, 32'h0);
    cyc(1'b1, 3'd1, 32'h55);
    cyc(1'b0, 3'd7, 32'h0);
    chk("fault_frozen", b0.addr_point, 32'h300);
    chk("deep_depth", 32'(b1.depth), 32'd3);
    do_reset();
    chk("mid_rst_depth", 32'(b1.depth), 32'd0);
    cyc(1'b1, 3'd5, 32'h0);
    cyc(1'b1, 3'd5, 32'h0);
    chk("udf_code", 32'(b1.fault_code), 32'd2);
    chk("udf_addr", b1.addr_point, BASE);
    cyc(1'b1, 3'd7, 32'h0);
    chk("recover_ready", 32'(b1.ready), 32'd1);
    chk("recover_fault", 32'(b1.fault), 32'd0);
    for (int k = 0; k < 800; k++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if ((mmode[0] == 2 || mmode[1] == 2) && $urandom_range(0, 3) == 0) o = 3'd7;
      if (o == 3'd7 && $urandom_range(0, 2) != 0) o = 3'd6;
      cyc(1'($urandom_range(0, 4) != 0), o, $urandom_range(0, 1) == 1 ? 32'($urandom) : 32'($urandom_range(0, 255)));
      if (k % 200 == 199) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_point_stack.md
Name: cmd_point_stack

Overview:
- Parametrised next-generation command pointer (program counter) for the command fetch path.
- Adds to the plain counter/jump/relative-jump function:
  - a hardware return-address stack (CALL/RET)
  - a stall enable
  - a soft restart opcode
  - a FAULT state for stack overflow/underflow
- Drives the command memory address; the sequencer consumes `ready` as "address valid".

Parameters:
- BUS_WIDTH, 32, width of addresses and of `addr_to`.
- CMD_POINT_BASE, 0, absolute address loaded at reset and on RST; `addr_point` is absolute.
- STACK_DEPTH, 8, number of return-address entries; legal range 1..256.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the `depth` output.

Ports:
- clk  in  1  clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; when low, no state changes (stall).
- opcode  in  3  command: NUL=000, JMP=001, SJF=010, CALL=011, SJB=100, RET=101, HOLD=110, RST=111.
- addr_to  in  BUS_WIDTH  jump target (JMP/CALL) or offset (SJF/SJB).
- addr_point  out  BUS_WIDTH  current command address (registered).
- ready  out  1  high when `addr_point` is valid and the block is in RUN.
- depth  out  DEPTH_W  number of valid stack entries.
- fault  out  1  high while in FAULT.
- fault_code  out  2  00 none, 01 overflow (CALL when full), 10 underflow (RET when empty); held while in FAULT.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - `addr_point` = CMD_POINT_BASE; `depth` = 0; `ready` = 0; `fault` = 0; `fault_code` = 00.
  - State = BOOT. Stack RAM contents are don't-care.
- States: BOOT, RUN, FAULT.
  - BOOT -> RUN on the first clk edge after reset release, regardless of `en`/`opcode`.
  - `ready` becomes 1 on that edge. Opcodes are ignored in BOOT.
- RUN, when `en`=1, one opcode per cycle, result visible the next cycle. Let P = current `addr_point`. All arithmetic is modulo 2^BUS_WIDTH, unsigned, wrap silently.
  - NUL: P+1.
  - JMP: `addr_to`.
  - SJF: P+`addr_to`.
  - SJB: P-`addr_to`.
  - CALL, `depth` < STACK_DEPTH: push P+1, `depth`+1, P <= `addr_to`.
  - CALL, `depth` == STACK_DEPTH: no push, P unchanged; -> FAULT, `fault_code` = 01.
  - RET, `depth` > 0: P <= top entry, `depth`-1.
  - RET, `depth` == 0: P unchanged; -> FAULT, `fault_code` = 10.
  - HOLD: P unchanged.
  - RST: P <= CMD_POINT_BASE; `depth` <= 0; stay in RUN.
- RUN, when `en`=0: nothing changes (P, `depth`, state); `ready` stays 1.
- FAULT:
  - `ready` = 0, `fault` = 1; P and `depth` frozen.
  - Every opcode except RST is ignored, whether `en` is 0 or 1.
  - RST with `en`=1: P <= CMD_POINT_BASE; `depth` <= 0; `fault_code` <= 00; -> RUN; `ready` = 1 the next cycle.
- Stack:
  - LIFO, register or LUT-RAM array.
  - Push writes entry[`depth`]; pop reads entry[`depth`-1].
  - The read is combinational into the P mux, so RET has the same 1-cycle latency as the other opcodes.
- Transition and latching rules:
  - FAULT is entered on the clk edge that samples the offending opcode; `ready` drops that same edge.
  - `fault_code` is latched on FAULT entry only and cleared only by RST or reset.
- Reset mid-operation: async, overrides everything; the stack is logically emptied (`depth` = 0).
- No simultaneous push/pop: one opcode per cycle by construction.

Test Plan:
- Reset release, `en`=1, opcode NUL for 4 cycles, CMD_POINT_BASE=0x100 -> `ready` 0 then 1 after 1 edge; `addr_point` 0x100,0x100,0x101,0x102,0x103.
- P=0x10: JMP 0x40 -> 0x40; SJF 0x8 -> 0x48; SJB 0x50 -> 0xFFFFFFF8 (wrap, BUS_WIDTH=32); `en`=0 for 3 cycles -> holds 0xFFFFFFF8.
- Nested calls: P=0x20, CALL 0x80, then at P=0x80 CALL 0xC0 -> `depth` 2; RET -> 0x81, `depth` 1; RET -> 0x21, `depth` 0.
- STACK_DEPTH=2, three CALLs -> third: `fault`=1, `fault_code`=01, `ready`=0, `depth`=2, P unchanged; following NUL/JMP ignored.
- From reset, RET -> FAULT, `fault_code`=10, P=CMD_POINT_BASE; then RST with `en`=1 -> next cycle `ready`=1, `fault`=0, `depth`=0, P=CMD_POINT_BASE.
- Assert `nreset` low mid-CALL chain (`depth`=3) -> immediately P=CMD_POINT_BASE, `depth`=0, `ready`=0; on release, BOOT then RUN, and RET faults with underflow.
